// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters (port 0 = execute stage,
//   port 1 = auxiliary/debug unit) with round-robin arbitration and valid/ready handshakes.
//   Operands are registered before the ALU and the result is registered after it, so
//   exactly one operation is in flight: IDLE -> EXEC -> RESP -> IDLE.
//   Owns the architectural status register {Z,C,N,V}; only ops with S set update it.
//
// Ports
//   i_clk, i_rst                    clock (rising edge), synchronous active-high reset
//   i_reqN_valid / o_reqN_ready     request handshake, N = 0,1 (ready is combinational)
//   i_reqN_cmd/_a/_b/_s             ALU command, operands, status-write enable
//   o_resp_valid / i_resp_ready     response handshake
//   o_resp_id/_data/_status         owning requester, registered ALU result and flags
//   o_alu_in1/_in2/_command/_cin    latched operands to the ALU, carry-in from status
//   i_alu_out, i_alu_status         ALU result and flags {Z,C,N,V}
//   o_status_reg                    architectural flags {Z,C,N,V}

module alu_share_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CMD_W  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req0_valid,
   output logic              o_req0_ready,
   input  logic [CMD_W-1:0]  i_req0_cmd,
   input  logic [DATA_W-1:0] i_req0_a,
   input  logic [DATA_W-1:0] i_req0_b,
   input  logic              i_req0_s,
   input  logic              i_req1_valid,
   output logic              o_req1_ready,
   input  logic [CMD_W-1:0]  i_req1_cmd,
   input  logic [DATA_W-1:0] i_req1_a,
   input  logic [DATA_W-1:0] i_req1_b,
   input  logic              i_req1_s,
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic              o_resp_id,
   output logic [DATA_W-1:0] o_resp_data,
   output logic [3:0]        o_resp_status,
   output logic [DATA_W-1:0] o_alu_in1,
   output logic [DATA_W-1:0] o_alu_in2,
   output logic [CMD_W-1:0]  o_alu_command,
   output logic              o_alu_cin,
   input  logic [DATA_W-1:0] i_alu_out,
   input  logic [3:0]        i_alu_status,
   output logic [3:0]        o_status_reg
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

   state_t            r_state;
   logic              r_last_grant;
   logic              r_s;
   logic [DATA_W-1:0] r_alu_in1;
   logic [DATA_W-1:0] r_alu_in2;
   logic [CMD_W-1:0]  r_alu_cmd;
   logic              r_resp_valid;
   logic              r_resp_id;
   logic [DATA_W-1:0] r_resp_data;
   logic [3:0]        r_resp_status;
   logic [3:0]        r_status_reg;

   logic w_idle;
   logic w_grant0;
   logic w_grant1;

   // A lone requester always wins; on contention the one not granted last time wins.
   assign w_idle   = (r_state == StIdle);
   assign w_grant0 = i_req0_valid & (~i_req1_valid | r_last_grant);
   assign w_grant1 = i_req1_valid & (~i_req0_valid | ~r_last_grant);

   assign o_req0_ready  = w_idle & w_grant0;
   assign o_req1_ready  = w_idle & w_grant1;
   assign o_resp_valid  = r_resp_valid;
   assign o_resp_id     = r_resp_id;
   assign o_resp_data   = r_resp_data;
   assign o_resp_status = r_resp_status;
   assign o_alu_in1     = r_alu_in1;
   assign o_alu_in2     = r_alu_in2;
   assign o_alu_command = r_alu_cmd;
   // Only one op is in flight, so the carry seen here is always the last S-op's carry.
   assign o_alu_cin     = r_status_reg[2];
   assign o_status_reg  = r_status_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_last_grant  <= 1'b1;
         r_s           <= 1'b0;
         r_alu_in1     <= '0;
         r_alu_in2     <= '0;
         r_alu_cmd     <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_id     <= 1'b0;
         r_resp_data   <= '0;
         r_resp_status <= '0;
         r_status_reg  <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_grant0 | w_grant1) begin
                  r_alu_in1    <= w_grant1 ? i_req1_a   : i_req0_a;
                  r_alu_in2    <= w_grant1 ? i_req1_b   : i_req0_b;
                  r_alu_cmd    <= w_grant1 ? i_req1_cmd : i_req0_cmd;
                  r_s          <= w_grant1 ? i_req1_s   : i_req0_s;
                  // last_grant doubles as the id of the op in flight
                  r_last_grant <= w_grant1;
                  r_state      <= StExec;
               end
            end
            StExec: begin
               r_resp_data   <= i_alu_out;
               r_resp_status <= i_alu_status;
               r_resp_id     <= r_last_grant;
               r_resp_valid  <= 1'b1;
               if (r_s) begin
                  r_status_reg <= i_alu_status;
               end
               r_state <= StResp;
            end
            StResp: begin
               if (i_resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: stub ALU, two request drivers, a response-ready driver,
// an acceptance model feeding an expectation queue and a response monitor draining it.

module tb_alu_share_arbiter;

   localparam logic [3:0] ADD_EXE = 4'd1;
   localparam logic [3:0] SUB_EXE = 4'd2;
   localparam logic [3:0] ADC_EXE = 4'd3;
   localparam logic [3:0] SBC_EXE = 4'd4;
   localparam logic [3:0] AND_EXE = 4'd5;
   localparam logic [3:0] OR_EXE  = 4'd6;
   localparam logic [3:0] XOR_EXE = 4'd7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0_valid, req0_ready, req0_s;
   logic [3:0]  req0_cmd;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_s;
   logic [3:0]  req1_cmd;
   logic [31:0] req1_a, req1_b;
   logic        resp_valid, resp_ready, resp_id;
   logic [31:0] resp_data;
   logic [3:0]  resp_status;
   logic [31:0] alu_in1, alu_in2, alu_out;
   logic [3:0]  alu_cmd, alu_status, status_reg;
   logic        alu_cin;

   alu_share_arbiter #(.DATA_W(32), .CMD_W(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_cmd(req0_cmd),
      .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_s(req0_s),
      .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_cmd(req1_cmd),
      .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_s(req1_s),
      .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_id(resp_id),
      .o_resp_data(resp_data), .o_resp_status(resp_status),
      .o_alu_in1(alu_in1), .o_alu_in2(alu_in2), .o_alu_command(alu_cmd),
      .o_alu_cin(alu_cin), .i_alu_out(alu_out), .i_alu_status(alu_status),
      .o_status_reg(status_reg)
   );

   // Reference ALU: returns {Z,C,N,V,result}.
   function automatic logic [35:0] alu_f(input logic [3:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
      logic [32:0] w;
      logic [31:0] r;
      logic        v;
      v = 1'b0;
      case (cmd)
         ADD_EXE: begin
            w = {1'b0, a} + {1'b0, b};
            v = (a[31] == b[31]) && (w[31] != a[31]);
         end
         ADC_EXE: begin
            w = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            v = (a[31] == b[31]) && (w[31] != a[31]);
         end
         SUB_EXE: begin
            w = {1'b0, a} + {1'b0, ~b} + 33'd1;
            v = (a[31] != b[31]) && (w[31] != a[31]);
         end
         SBC_EXE: begin
            w = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
            v = (a[31] != b[31]) && (w[31] != a[31]);
         end
         AND_EXE: w = {1'b0, a & b};
         OR_EXE:  w = {1'b0, a | b};
         XOR_EXE: w = {1'b0, a ^ b};
         default: w = {1'b0, a};
      endcase
      r = w[31:0];
      return {(r == 32'd0), w[32], r[31], v, r};
   endfunction

   always_comb {alu_status, alu_out} = alu_f(alu_cmd, alu_in1, alu_in2, alu_cin);

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic [3:0]  st;
      logic [3:0]  sreg;
      int          acc;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0, n_err = 0, cyc = 0;
   int n_acc = 0, n_resp = 0, n_drop = 0, n_issue = 0;
   int rr_mode = 0;   // 0: always ready, 1: random, 2: stalled

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Acceptance model: arbitration rule, serialisation and status-register history.
   logic       m_busy = 1'b0;
   logic       m_last = 1'b1;
   logic [3:0] m_sreg = 4'd0;

   always @(negedge clk) begin : acc_mon
      logic        e0, e1, id, s;
      logic [3:0]  cmd;
      logic [31:0] a, b;
      logic [35:0] r;
      exp_t        e;
      if (rst) begin
         m_busy = 1'b0;
         m_last = 1'b1;
         m_sreg = 4'd0;
      end else begin
         e0 = !m_busy && req0_valid && (!req1_valid || m_last);
         e1 = !m_busy && req1_valid && (!req0_valid || !m_last);
         chk("req0_ready", req0_ready, e0);
         chk("req1_ready", req1_ready, e1);
         if (e0 || e1) begin
            id  = e1;
            cmd = id ? req1_cmd : req0_cmd;
            a   = id ? req1_a : req0_a;
            b   = id ? req1_b : req0_b;
            s   = id ? req1_s : req0_s;
            r   = alu_f(cmd, a, b, m_sreg[2]);
            if (s) m_sreg = r[35:32];
            e.id   = id;
            e.data = r[31:0];
            e.st   = r[35:32];
            e.sreg = m_sreg;
            e.acc  = cyc;
            q.push_back(e);
            n_acc++;
            m_last = id;
            m_busy = 1'b1;
         end else if (m_busy && resp_valid && resp_ready) begin
            m_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin : resp_mon
      exp_t e;
      if (rst) begin
         n_drop += q.size();
         q.delete();
      end else if (q.size() == 0) begin
         chk("resp_valid_idle", resp_valid, 0);
      end else begin
         e = q[0];
         chk("resp_valid_timing", resp_valid, (cyc >= e.acc + 2));
         if (resp_valid) begin
            chk("resp_id", resp_id, e.id);
            chk("resp_data", resp_data, e.data);
            chk("resp_status", resp_status, e.st);
            chk("status_reg", status_reg, e.sreg);
            if (resp_ready) begin
               void'(q.pop_front());
               n_resp++;
            end
         end
      end
   end

   initial begin : rr_drv
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = ($urandom_range(0, 2) != 0);
            default: resp_ready = 1'b0;
         endcase
      end
   end

   task automatic drive(input int p, input logic v, input logic [3:0] cmd,
                        input logic [31:0] a, input logic [31:0] b, input logic s);
      if (p == 1) begin
         req1_valid = v; req1_cmd = cmd; req1_a = a; req1_b = b; req1_s = s;
      end else begin
         req0_valid = v; req0_cmd = cmd; req0_a = a; req0_b = b; req0_s = s;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue(input int p, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
      int          n;
      logic [31:0] junk;
      n = 0;
      drive(p, 1'b1, cmd, a, b, s);
      do begin
         @(negedge clk);
         n++;
      end while (!(p == 1 ? req1_ready : req0_ready) && n < 100);
      if (n >= 100) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: port %0d got no ready in %0d cycles, expected accept", p, n);
      end else begin
         n_issue++;
      end
      @(posedge clk);
      #1;
      junk = $urandom();
      drive(p, 1'b0, junk[3:0], $urandom(), $urandom(), junk[4]);
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((q.size() != 0 || m_busy) && n < 200);
      if (n >= 200) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_req0_ready"}, req0_ready, 0);
      chk({tag, "_req1_ready"}, req1_ready, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_id"}, resp_id, 0);
      chk({tag, "_resp_data"}, resp_data, 0);
      chk({tag, "_resp_status"}, resp_status, 0);
      chk({tag, "_alu_in1"}, alu_in1, 0);
      chk({tag, "_alu_in2"}, alu_in2, 0);
      chk({tag, "_alu_cmd"}, alu_cmd, 0);
      chk({tag, "_alu_cin"}, alu_cin, 0);
      chk({tag, "_status_reg"}, status_reg, 0);
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_zero(tag);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] rnd_cmd();
      case ($urandom_range(0, 6))
         0:       return ADD_EXE;
         1:       return SUB_EXE;
         2:       return ADC_EXE;
         3:       return SBC_EXE;
         4:       return AND_EXE;
         5:       return OR_EXE;
         default: return XOR_EXE;
      endcase
   endfunction

   function automatic logic [31:0] rnd_data();
      case ($urandom_range(0, 4))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   task automatic rnd_port(input int p, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
         issue(p, rnd_cmd(), rnd_data(), rnd_data(), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst = 1'b1;
      resp_ready = 1'b0;
      drive(0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      drive(1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      pulse_reset("reset");

      // Single op, latency and flags.
      issue(0, ADD_EXE, 32'd5, 32'd7, 1'b1);
      drain();
      // Zero flag set by S-op, untouched by non-S op.
      issue(0, SUB_EXE, 32'd3, 32'd3, 1'b1);
      drain();
      issue(1, ADD_EXE, 32'd1, 32'd1, 1'b0);
      drain();
      // Carry chain into ADC.
      issue(1, ADD_EXE, 32'hFFFF_FFFF, 32'd1, 1'b1);
      drain();
      issue(0, ADC_EXE, 32'd1, 32'd1, 1'b0);
      drain();

      // Both saturating from reset: grants must alternate starting with port 0.
      pulse_reset("reset2");
      fork
         for (int i = 0; i < 4; i++) issue(0, ADD_EXE, 32'(i), 32'd100, 1'b0);
         for (int i = 0; i < 4; i++) issue(1, SUB_EXE, 32'd200, 32'(i), 1'b0);
      join
      drain();

      // Response back-pressure with a competing request waiting.
      rr_mode = 2;
      fork
         issue(0, XOR_EXE, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 1'b1);
         begin
            @(posedge clk);
            #1;
            issue(1, OR_EXE, 32'h1234_0000, 32'h0000_5678, 1'b0);
         end
         begin
            for (int n = 0; n < 50 && !resp_valid; n++) @(negedge clk);
            repeat (5) @(negedge clk);
            chk("stall_resp_valid", resp_valid, 1);
            rr_mode = 0;
         end
      join
      drain();

      // Reset while the op is in EXEC: it must vanish.
      issue(0, ADD_EXE, 32'hFFFF_FFFF, 32'd1, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_zero("rst_exec");
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      fork
         issue(0, AND_EXE, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b1);
         issue(1, ADD_EXE, 32'd9, 32'd9, 1'b1);
      join
      drain();

      // Random traffic on both ports with random back-pressure.
      rr_mode = 1;
      fork
         rnd_port(0, 30);
         rnd_port(1, 30);
      join
      drain();
      rr_mode = 0;

      chk("queue_empty", q.size(), 0);
      chk("accepted_vs_issued", n_acc, n_issue);
      chk("responses_accounted", n_resp + n_drop, n_acc);
      chk("dropped_count", n_drop, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
